// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 encodings, execute-stage state and output bundle types.
package riscv_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] F7_MUL    = 7'b0000001;
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;
    localparam logic [1:0] ALUOP_RSV = 2'b11;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {IDLE, MUL} ex_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        redirect;
        logic [31:0] redirect_pc;
    } ex_out_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction
endpackage

// File: rtl/mul_iter.sv
// mul_iter: 32-iteration shift-add multiplier, low 32 product bits, freezes while hold is high.
module mul_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hold,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    logic [31:0] acc, mcand, mplier;
    logic [4:0]  cnt;

    // product already includes the current iteration, so it is final on the done edge
    assign product = acc + (mplier[0] ? mcand : 32'd0);
    assign done    = busy && !hold && cnt == 5'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= 5'd31;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (busy && !hold) begin
            busy   <= cnt != 5'd0;
            cnt    <= cnt - 5'd1;
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage with inline ALU/branch unit and an iterative multiplier.
module ex_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [6:0]  opcode_in,
    input  logic [2:0]  funct3_in,
    input  logic [6:0]  funct7_in,
    input  logic [31:0] rs1_in,
    input  logic [31:0] rs2_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [11:0] imm_in,
    input  logic [19:0] imm_j_in,
    input  logic [31:0] pc_in,
    input  logic        RegWrite_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        MemtoReg_in,
    input  logic        ALUSrc_in,
    input  logic        Jump_in,
    input  logic [1:0]  ALUOp_in,
    input  logic        stall_in,
    output logic        stall_out,
    output logic        valid_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic [4:0]  rd_addr_out,
    output logic        RegWrite_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        MemtoReg_out,
    output logic        redirect_out,
    output logic [31:0] redirect_pc_out
);
    ex_state_t   state, state_nx;
    ex_out_t     q, q_nx, res, mul_tpl;
    logic        accept, is_mul, mul_start, mul_busy, mul_done;
    logic        is_sub, eq, lt, ltu, taken;
    logic [4:0]  shamt;
    logic [31:0] op2, alu, sra, mul_prod, br_tgt, j_tgt;

    assign accept    = valid_in && state == IDLE && !stall_in;
    assign is_mul    = opcode_in == OP_R && funct7_in == F7_MUL && funct3_in == F3_ADD;
    assign mul_start = accept && is_mul;
    assign stall_out = state == MUL || stall_in;
    assign op2       = ALUSrc_in ? sext12(imm_in) : rs2_in;
    assign shamt     = op2[4:0];
    assign is_sub    = opcode_in == OP_R && funct7_in[5];
    assign sra       = $signed(rs1_in) >>> shamt;
    assign eq        = rs1_in == op2;
    assign lt        = $signed(rs1_in) < $signed(op2);
    assign ltu       = rs1_in < op2;
    assign br_tgt    = pc_in + {{19{imm_in[11]}}, imm_in, 1'b0};
    assign j_tgt     = pc_in + {{11{imm_j_in[19]}}, imm_j_in, 1'b0};
    assign taken     = funct3_in == F3_BEQ  ? eq :
                       funct3_in == F3_BNE  ? !eq :
                       funct3_in == F3_BLT  ? lt :
                       funct3_in == F3_BGE  ? !lt :
                       funct3_in == F3_BLTU ? ltu :
                       funct3_in == F3_BGEU ? !ltu : 1'b0;

    always_comb begin
        alu = '0;
        case (ALUOp_in)
            ALUOP_ADD: alu = rs1_in + op2;
            ALUOP_BR:  alu = rs1_in - op2;
            ALUOP_FN:
                case (funct3_in)
                    F3_ADD:  alu = is_sub ? rs1_in - op2 : rs1_in + op2;
                    F3_SLL:  alu = rs1_in << shamt;
                    F3_SLT:  alu = {31'b0, lt};
                    F3_SLTU: alu = {31'b0, ltu};
                    F3_XOR:  alu = rs1_in ^ op2;
                    F3_SR:   alu = funct7_in[5] ? sra : rs1_in >> shamt;
                    F3_OR:   alu = rs1_in | op2;
                    F3_AND:  alu = rs1_in & op2;
                endcase
            default:   alu = '0;
        endcase
    end

    always_comb begin
        res             = '0;
        res.valid       = 1'b1;
        res.alu         = Jump_in ? pc_in + 32'd4 : alu;
        res.store       = rs2_in;
        res.rd          = rd_addr_in;
        res.reg_write   = RegWrite_in && (Jump_in || ALUOp_in != ALUOP_BR);
        res.mem_read    = MemRead_in;
        res.mem_write   = MemWrite_in;
        res.mem_to_reg  = MemtoReg_in;
        res.redirect    = Jump_in || (ALUOp_in == ALUOP_BR && taken);
        res.redirect_pc = Jump_in ? j_tgt : res.redirect ? br_tgt : 32'd0;
    end

    mul_iter u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .hold    (stall_in),
        .a       (rs1_in),
        .b       (op2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // a multiply's destination/controls are captured at accept and reused on completion
    always_comb begin
        q_nx     = '0;
        state_nx = state;
        if (stall_in) q_nx = q;
        else if (mul_done) begin
            q_nx     = mul_tpl;
            q_nx.alu = mul_prod;
        end else if (accept && !is_mul) q_nx = res;
        if (mul_start) state_nx = MUL;
        else if (state == MUL && (mul_done || !mul_busy)) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            q       <= '0;
            mul_tpl <= '0;
        end else begin
            state <= state_nx;
            q     <= q_nx;
            if (mul_start) mul_tpl <= res;
        end
    end

    assign valid_out       = q.valid;
    assign alu_result_out  = q.alu;
    assign store_data_out  = q.store;
    assign rd_addr_out     = q.rd;
    assign RegWrite_out    = q.reg_write;
    assign MemRead_out     = q.mem_read;
    assign MemWrite_out    = q.mem_write;
    assign MemtoReg_out    = q.mem_to_reg;
    assign redirect_out    = q.redirect;
    assign redirect_pc_out = q.redirect_pc;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scoreboard bench for ex_stage.
module tb_ex_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, valid_in = 1'b0, stall_in = 1'b0;
    logic [6:0]  opcode_in = '0, funct7_in = '0;
    logic [2:0]  funct3_in = '0;
    logic [31:0] rs1_in = '0, rs2_in = '0, pc_in = '0;
    logic [4:0]  rd_addr_in = '0;
    logic [11:0] imm_in = '0;
    logic [19:0] imm_j_in = '0;
    logic [1:0]  ALUOp_in = '0;
    logic        RegWrite_in = 1'b0, MemRead_in = 1'b0, MemWrite_in = 1'b0;
    logic        MemtoReg_in = 1'b0, ALUSrc_in = 1'b0, Jump_in = 1'b0;
    logic        stall_out, valid_out, RegWrite_out, MemRead_out, MemWrite_out, MemtoReg_out, redirect_out;
    logic [31:0] alu_result_out, store_data_out, redirect_pc_out;
    logic [4:0]  rd_addr_out;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .opcode_in(opcode_in), .funct3_in(funct3_in), .funct7_in(funct7_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_addr_in(rd_addr_in),
        .imm_in(imm_in), .imm_j_in(imm_j_in), .pc_in(pc_in),
        .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemtoReg_in(MemtoReg_in), .ALUSrc_in(ALUSrc_in), .Jump_in(Jump_in),
        .ALUOp_in(ALUOp_in), .stall_in(stall_in), .stall_out(stall_out),
        .valid_out(valid_out), .alu_result_out(alu_result_out), .store_data_out(store_data_out),
        .rd_addr_out(rd_addr_out), .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out),
        .MemWrite_out(MemWrite_out), .MemtoReg_out(MemtoReg_out),
        .redirect_out(redirect_out), .redirect_pc_out(redirect_pc_out)
    );

    typedef struct {
        int          id;
        logic        chk_alu;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, fails = 0;

    task automatic chk(input string tag, input int id, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s #%0d observed=0x%08h expected=0x%08h", tag, id, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic ca, input logic [31:0] alu, input logic [4:0] rd,
                        input logic rw, input logic redir, input logic [31:0] rpc);
        exp_t e;
        e.id = id; e.chk_alu = ca; e.alu = alu; e.rd = rd; e.rw = rw; e.redir = redir; e.rpc = rpc;
        sb.push_back(e);
    endtask

    // every valid result is matched against the oldest outstanding expectation
    task automatic tick(input bit mon = 1'b1);
        exp_t e;
        @(posedge clk);
        #1;
        if (mon && valid_out === 1'b1) begin
            if (sb.size() == 0) chk("unexpected_valid", 0, {31'b0, valid_out}, 32'd0);
            else begin
                e = sb.pop_front();
                if (e.chk_alu) chk("alu", e.id, alu_result_out, e.alu);
                chk("rd", e.id, {27'b0, rd_addr_out}, {27'b0, e.rd});
                chk("regwrite", e.id, {31'b0, RegWrite_out}, {31'b0, e.rw});
                chk("redirect", e.id, {31'b0, redirect_out}, {31'b0, e.redir});
                if (e.redir) chk("redirect_pc", e.id, redirect_pc_out, e.rpc);
            end
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [11:0] imm,
                         input logic [1:0] aop, input logic src, input logic [4:0] rd);
        valid_in = 1'b1; opcode_in = op; funct3_in = f3; funct7_in = f7;
        rs1_in = a; rs2_in = b; imm_in = imm; ALUOp_in = aop; ALUSrc_in = src; rd_addr_in = rd;
        RegWrite_in = 1'b1; MemRead_in = 1'b0; MemWrite_in = 1'b0; MemtoReg_in = 1'b0; Jump_in = 1'b0;
    endtask

    task automatic run_mul(input int id, input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                           input int s0, input int slen, input int cycles);
        int n = 0;
        issue(OP_R, F3_ADD, F7_MUL, a, b, 12'd0, ALUOP_FN, 1'b0, 5'd10);
        push(id, 1'b1, p, 5'd10, 1'b1, 1'b0, 32'd0);
        tick();
        // ID keeps presenting a younger bundle while the multiply is running
        issue(OP_R, F3_ADD, 7'd0, 32'd1, 32'd1, 12'd0, ALUOP_FN, 1'b0, 5'd9);
        while (stall_out === 1'b1 && n < 80) begin
            n++;
            stall_in = (n >= s0 && n < s0 + slen);
            tick();
        end
        valid_in = 1'b0;
        stall_in = 1'b0;
        chk("mul_stall_cycles", id, n, cycles);
        chk("mul_valid", id, {31'b0, valid_out}, 32'd1);
        tick();
        chk("mul_bubble", id, {31'b0, valid_out}, 32'd0);
    endtask

    initial begin
        issue(OP_R, F3_ADD, 7'd0, 32'd1, 32'd2, 12'd0, ALUOP_FN, 1'b0, 5'd1);
        tick(); tick();
        chk("rst_valid", 0, {31'b0, valid_out}, 32'd0);
        chk("rst_alu", 0, alu_result_out, 32'd0);
        chk("rst_redirect", 0, {31'b0, redirect_out}, 32'd0);
        chk("rst_redirect_pc", 0, redirect_pc_out, 32'd0);
        chk("rst_stall", 0, {31'b0, stall_out}, 32'd0);
        valid_in = 1'b0;
        rst = 1'b0;
        tick();

        issue(OP_R, F3_ADD, 7'h00, 32'd5, 32'd7, 12'd0, ALUOP_FN, 1'b0, 5'd3);
        push(1, 1'b1, 32'd12, 5'd3, 1'b1, 1'b0, 32'd0); tick();
        issue(OP_R, F3_ADD, 7'h20, 32'd5, 32'd7, 12'd0, ALUOP_FN, 1'b0, 5'd4);
        push(2, 1'b1, 32'hFFFF_FFFE, 5'd4, 1'b1, 1'b0, 32'd0); tick();
        issue(OP_R, F3_SR, 7'h20, 32'h8000_0000, 32'h24, 12'd0, ALUOP_FN, 1'b0, 5'd5);
        push(3, 1'b1, 32'hF800_0000, 5'd5, 1'b1, 1'b0, 32'd0); tick();
        issue(OP_R, F3_SR, 7'h00, 32'h8000_0000, 32'h24, 12'd0, ALUOP_FN, 1'b0, 5'd6);
        push(4, 1'b1, 32'h0800_0000, 5'd6, 1'b1, 1'b0, 32'd0); tick();
        issue(OP_R, F3_SLT, 7'h00, 32'hFFFF_FFFF, 32'd1, 12'd0, ALUOP_FN, 1'b0, 5'd7);
        push(5, 1'b1, 32'd1, 5'd7, 1'b1, 1'b0, 32'd0); tick();
        issue(OP_R, F3_SLTU, 7'h00, 32'hFFFF_FFFF, 32'd1, 12'd0, ALUOP_FN, 1'b0, 5'd7);
        push(6, 1'b1, 32'd0, 5'd7, 1'b1, 1'b0, 32'd0); tick();
        issue(OP_I, F3_SLL, 7'h20, 32'd3, 32'd99, 12'h021, ALUOP_FN, 1'b1, 5'd8);
        push(7, 1'b1, 32'd6, 5'd8, 1'b1, 1'b0, 32'd0); tick();
        issue(OP_I, F3_ADD, 7'h20, 32'd10, 32'd99, 12'd3, ALUOP_FN, 1'b1, 5'd8);
        push(8, 1'b1, 32'd13, 5'd8, 1'b1, 1'b0, 32'd0); tick();
        issue(OP_STORE, 3'b010, 7'h00, 32'h1000, 32'hCAFE, 12'hFFC, ALUOP_ADD, 1'b1, 5'd0);
        MemWrite_in = 1'b1; RegWrite_in = 1'b0;
        push(9, 1'b1, 32'h0FFC, 5'd0, 1'b0, 1'b0, 32'd0); tick();
        chk("store_data", 9, store_data_out, 32'hCAFE);
        chk("store_memwrite", 9, {31'b0, MemWrite_out}, 32'd1);
        issue(OP_R, F3_XOR, 7'h00, 32'hF0F0, 32'h0FF0, 12'd0, ALUOP_FN, 1'b0, 5'd2);
        push(10, 1'b1, 32'hFF00, 5'd2, 1'b1, 1'b0, 32'd0); tick();
        issue(OP_R, F3_OR, 7'h00, 32'hF0F0, 32'h0FF0, 12'd0, ALUOP_FN, 1'b0, 5'd2);
        push(11, 1'b1, 32'hFFF0, 5'd2, 1'b1, 1'b0, 32'd0); tick();
        issue(OP_R, F3_AND, 7'h00, 32'hF0F0, 32'h0FF0, 12'd0, ALUOP_FN, 1'b0, 5'd2);
        push(12, 1'b1, 32'h00F0, 5'd2, 1'b1, 1'b0, 32'd0); tick();
        issue(OP_R, F3_ADD, 7'h00, 32'd5, 32'd7, 12'd0, ALUOP_RSV, 1'b0, 5'd2);
        push(13, 1'b1, 32'd0, 5'd2, 1'b1, 1'b0, 32'd0); tick();
        valid_in = 1'b0;
        tick();
        chk("bubble_valid", 14, {31'b0, valid_out}, 32'd0);
        chk("bubble_regwrite", 14, {31'b0, RegWrite_out}, 32'd0);
        chk("bubble_alu", 14, alu_result_out, 32'd0);

        issue(OP_R, F3_ADD, 7'h00, 32'd20, 32'd22, 12'd0, ALUOP_FN, 1'b0, 5'd8);
        push(15, 1'b1, 32'd42, 5'd8, 1'b1, 1'b0, 32'd0); tick();
        stall_in = 1'b1;
        issue(OP_R, F3_ADD, 7'h00, 32'd1, 32'd1, 12'd0, ALUOP_FN, 1'b0, 5'd9);
        tick(1'b0);
        chk("hold_valid", 15, {31'b0, valid_out}, 32'd1);
        chk("hold_alu", 15, alu_result_out, 32'd42);
        chk("hold_stall_out", 15, {31'b0, stall_out}, 32'd1);
        stall_in = 1'b0; valid_in = 1'b0;
        tick();
        chk("hold_release", 15, {31'b0, valid_out}, 32'd0);

        issue(OP_BRANCH, F3_BNE, 7'h00, 32'd1, 32'd2, 12'd8, ALUOP_BR, 1'b0, 5'd0); pc_in = 32'h100;
        push(20, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 32'h110); tick();
        issue(OP_BRANCH, F3_BEQ, 7'h00, 32'd1, 32'd2, 12'd8, ALUOP_BR, 1'b0, 5'd0); pc_in = 32'h100;
        push(21, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0); tick();
        issue(OP_BRANCH, F3_BLT, 7'h00, 32'hFFFF_FFFF, 32'd1, 12'hFFE, ALUOP_BR, 1'b0, 5'd0); pc_in = 32'h200;
        push(22, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 32'h1FC); tick();
        issue(OP_BRANCH, F3_BLTU, 7'h00, 32'hFFFF_FFFF, 32'd1, 12'hFFE, ALUOP_BR, 1'b0, 5'd0); pc_in = 32'h200;
        push(23, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0); tick();
        issue(OP_BRANCH, F3_BGE, 7'h00, 32'd5, 32'd5, 12'd4, ALUOP_BR, 1'b0, 5'd0); pc_in = 32'h40;
        push(24, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 32'h48); tick();
        issue(OP_BRANCH, F3_BGEU, 7'h00, 32'd1, 32'd2, 12'd4, ALUOP_BR, 1'b0, 5'd0); pc_in = 32'h40;
        push(25, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0); tick();
        issue(OP_JAL, 3'd0, 7'h00, 32'd0, 32'd0, 12'd0, ALUOP_ADD, 1'b0, 5'd1);
        Jump_in = 1'b1; imm_j_in = 20'h00010; pc_in = 32'h300;
        push(26, 1'b1, 32'h304, 5'd1, 1'b1, 1'b1, 32'h320); tick();
        issue(OP_JAL, 3'd0, 7'h00, 32'd0, 32'd0, 12'd0, ALUOP_ADD, 1'b0, 5'd1);
        Jump_in = 1'b1; imm_j_in = 20'hFFFFE; pc_in = 32'h300;
        push(27, 1'b1, 32'h304, 5'd1, 1'b1, 1'b1, 32'h2FC); tick();
        valid_in = 1'b0; Jump_in = 1'b0;
        tick();
        chk("redirect_one_cycle", 27, {31'b0, redirect_out}, 32'd0);

        run_mul(30, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 99, 0, 32);
        run_mul(31, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 10, 3, 35);
        run_mul(32, 32'hDEAD_BEEF, 32'h0123_4567, 32'hDEAD_BEEF * 32'h0123_4567, 32, 2, 34);

        issue(OP_R, F3_ADD, F7_MUL, 32'd7, 32'd9, 12'd0, ALUOP_FN, 1'b0, 5'd10);
        tick();
        valid_in = 1'b0;
        repeat (10) tick();
        chk("abort_busy", 40, {31'b0, stall_out}, 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_valid", 40, {31'b0, valid_out}, 32'd0);
        chk("abort_stall", 40, {31'b0, stall_out}, 32'd0);
        chk("abort_alu", 40, alu_result_out, 32'd0);
        chk("abort_redirect", 40, {31'b0, redirect_out}, 32'd0);
        rst = 1'b0;
        issue(OP_R, F3_ADD, 7'h00, 32'd100, 32'd23, 12'd0, ALUOP_FN, 1'b0, 5'd11);
        push(41, 1'b1, 32'd123, 5'd11, 1'b1, 1'b0, 32'd0); tick();
        chk("post_rst_valid", 41, {31'b0, valid_out}, 32'd1);
        valid_in = 1'b0;
        repeat (40) tick();
        chk("post_rst_idle", 41, {31'b0, stall_out}, 32'd0);
        chk("scoreboard_empty", 0, sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
